// File: rtl/cla_seq_ctrl_if.sv
// rtl/cla_seq_ctrl_if.sv - request/response and slice signals of the sequenced CLA controller
interface cla_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  // operand request
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  // result response
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  // shared external 4-bit CLA slice
  logic [3:0]       sl_x;
  logic [3:0]       sl_y;
  logic             sl_cin;
  logic [3:0]       sl_z;
  logic             sl_cout;

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready, sl_z, sl_cout,
    output in_ready, out_valid, sum, cout, ovf, sl_x, sl_y, sl_cin
  );

  modport master (
    output in_valid, a, b, sub, cin, out_ready, sl_z, sl_cout,
    input  in_ready, out_valid, sum, cout, ovf, sl_x, sl_y, sl_cin
  );
endinterface

// File: rtl/cla_seq_ctrl.sv
// rtl/cla_seq_ctrl.sv - runs one shared 4-bit CLA slice over WIDTH/4 cycles, LSB nibble first
module cla_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cla_seq_ctrl_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_release;
  logic [KW+1:0]    w_base;

  assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
  assign w_last    = (r_state == S_RUN) && (r_k == K_LAST);
  assign w_release = (r_state == S_DONE) && bus.out_ready;
  assign w_base    = {r_k, 2'b00};

  // state register; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state: accept -> run NIB nibbles -> hold result until taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (w_release) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // slice drive: current nibble of a and b', zero whenever not running
  always_comb begin
    bus.sl_x   = 4'd0;
    bus.sl_y   = 4'd0;
    bus.sl_cin = 1'b0;
    if (r_state == S_RUN) begin
      bus.sl_x   = r_a[w_base +: 4];
      bus.sl_y   = r_b[w_base +: 4];
      bus.sl_cin = r_carry;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

  // operand capture on accept, nibble accumulation and final flags while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // subtract is a + ~b + 1, so invert b and force the first carry
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_sum   <= '0;
            r_k     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        S_RUN: begin
          r_sum[w_base +: 4] <= bus.sl_z;
          r_carry            <= bus.sl_cout;
          if (w_last) begin
            r_k    <= '0;
            r_cout <= bus.sl_cout;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (bus.sl_z[3] != r_a[WIDTH-1]);
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb/tb_cla_seq_ctrl.sv - randomized self-checking bench for cla_seq_ctrl against an arithmetic model
module tb_cla_seq_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  cla_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ideal 4-bit slice
  assign {bus.sl_cout, bus.sl_z} = 5'(bus.sl_x) + 5'(bus.sl_y) + 5'(bus.sl_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // integer-arithmetic reference: result modulo 2^16, carry/no-borrow, signed range overflow
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                input logic cin, output logic [15:0] s, output logic co,
                                output logic ov);
    int ua, ub, sa, sb, tot, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      tot = ua - ub;
      co  = (ua >= ub);
      sr  = sa - sb;
    end else begin
      tot = ua + ub + int'(cin);
      co  = (tot >= 65536);
      sr  = sa + sb + int'(cin);
    end
    s  = tot[15:0];
    ov = (sr > 32767) || (sr < -32768);
  endfunction

  task automatic spam_inputs(input bit spam);
    if (spam) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.sub      = 1'($urandom_range(0, 1));
      bus.cin      = 1'($urandom_range(0, 1));
    end else begin
      bus.in_valid = 1'b0;
    end
  endtask

  // called and returns at a falling edge; accept happens at the next rising edge
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic cin, input int hold, input bit spam);
    logic [15:0] es, bp;
    logic        eco, eov, c0;
    int          lat;
    logic [15:0] mask;
    model(a, b, sub, cin, es, eco, eov);
    bp = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    bus.a         = a;
    bus.b         = b;
    bus.sub       = sub;
    bus.cin       = cin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_sl_x", 32'(bus.sl_x), 32'd0);
    @(posedge clk);
    @(negedge clk);
    spam_inputs(spam);
    check("run0_sl_cin", 32'(bus.sl_cin), 32'(c0));
    check("run0_sl_x", 32'(bus.sl_x), 32'(a[3:0]));
    check("run0_sl_y", 32'(bus.sl_y), 32'(bp[3:0]));
    check("run0_in_ready", 32'(bus.in_ready), 32'd0);
    check("run0_sum_clear", 32'(bus.sum), 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      spam_inputs(spam);
      if (!bus.out_valid && lat < NIB) begin
        mask = 16'((32'd1 << (4 * lat)) - 1);
        check("partial_sum", 32'(bus.sum), 32'(es & mask));
      end
    end while (!bus.out_valid && lat < 20);
    check("latency", 32'(lat), 32'(NIB));
    for (int i = 0; i <= hold; i++) begin
      check("done_valid", 32'(bus.out_valid), 32'd1);
      check("done_sum", 32'(bus.sum), 32'(es));
      check("done_cout", 32'(bus.cout), 32'(eco));
      check("done_ovf", 32'(bus.ovf), 32'(eov));
      check("done_in_ready", 32'(bus.in_ready), 32'd0);
      if (i < hold) begin
        @(posedge clk);
        @(negedge clk);
        spam_inputs(spam);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // reset after two nibbles; operation must vanish without an out_valid pulse
  task automatic reset_mid_run();
    bus.a        = 16'h1234;
    bus.b        = 16'h4321;
    bus.sub      = 1'b0;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_sl_x", 32'(bus.sl_x), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("rst_no_pulse", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_sum", 32'(bus.sum), 32'd0);
    check("reset_cout", 32'(bus.cout), 32'd0);
    check("reset_ovf", 32'(bus.ovf), 32'd0);
    check("reset_sl_cin", 32'(bus.sl_cin), 32'd0);
    rst_n = 1'b1;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 3, 1'b1);
    reset_mid_run();
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
